// File: rtl/axi4lite_master_controller.sv
// -----------------------------------------------------------------------------
// axi4lite_master_controller
//
// Cache-side AXI4-Lite initiator. Converts single-word cache requests (refill
// reads, write-back / write-through writes) into AXI4-Lite transactions, one at
// a time, and reports completion to the cache with a one-cycle rsp_valid pulse.
//
// Optional feature macro: AXI4LITE_RESP_CHECK_EN
//   defined   : rresp/bresp are captured; rsp_err flags SLVERR/DECERR.
//   undefined : responses are ignored and rsp_err is tied low.
//
// Ports
//   aclk, aresetn              clock (rising edge), async active-low reset
//   req_valid/req_ready        cache request handshake
//   req_we, req_addr, req_wdata  request kind, word address, write data
//   rsp_valid, rsp_rdata, rsp_err  completion pulse, read data, error flag
//   araddr/arvalid/arready     AXI read address channel
//   rdata/rresp/rvalid/rready  AXI read data channel
//   awaddr/awvalid/awready     AXI write address channel
//   wdata/wstrb/wvalid/wready  AXI write data channel
//   bresp/bvalid/bready        AXI write response channel
// -----------------------------------------------------------------------------
module axi4lite_master_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // cache request side
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    // cache response side
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // AXI read address channel
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    // AXI read data channel
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    // AXI write address channel
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    // AXI write data channel
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    // AXI write response channel
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_WRESP = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;

    // Latched request and captured response
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [STRB_WIDTH-1:0]   wstrb_r;
    logic [DATA_WIDTH-1:0]   rdata_r;

    // Per-channel completion flags for the write address / write data pair
    logic                    aw_done_r;
    logic                    w_done_r;

    // Decoded control outputs (functions of registered state only)
    logic                    req_ready_s;
    logic                    arvalid_s;
    logic                    rready_s;
    logic                    awvalid_s;
    logic                    wvalid_s;
    logic                    bready_s;
    logic                    rsp_valid_s;

    logic                    aw_hs_s;
    logic                    w_hs_s;

    // SLVERR (2'b10) and DECERR (2'b11) both have the upper bit set.
    function automatic logic is_error_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

    assign aw_hs_s = awvalid_s & awready;
    assign w_hs_s  = wvalid_s & wready;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = req_we ? ST_WRITE : ST_RADDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (arready) begin
                    state_next_s = ST_RDATA;
                end else begin
                    state_next_s = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (rvalid) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_RDATA;
                end
            end
            ST_WRITE: begin
                // AW and W may complete in the same or in different cycles.
                if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
                    state_next_s = ST_WRESP;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_WRESP: begin
                if (bvalid) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WRESP;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register and registered done flags
    always_comb begin
        req_ready_s = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        rsp_valid_s = 1'b0;
        case (state_r)
            ST_IDLE:  req_ready_s = 1'b1;
            ST_RADDR: arvalid_s   = 1'b1;
            ST_RDATA: rready_s    = 1'b1;
            ST_WRITE: begin
                // Each valid drops the cycle after its own handshake.
                awvalid_s = ~aw_done_r;
                wvalid_s  = ~w_done_r;
            end
            ST_WRESP: bready_s    = 1'b1;
            ST_RESP:  rsp_valid_s = 1'b1;
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // Request capture, write-channel done tracking and read data capture
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_r    <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
            wstrb_r   <= {STRB_WIDTH{1'b0}};
            rdata_r   <= {DATA_WIDTH{1'b0}};
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if (req_we) begin
                            // Full-word writes only; strobe stays set afterwards.
                            wstrb_r <= {STRB_WIDTH{1'b1}};
                        end
                    end
                end
                ST_WRITE: begin
                    if (aw_hs_s) begin
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        w_done_r <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    // rsp_rdata is only refreshed by reads; writes leave it alone.
                    if (rvalid) begin
                        rdata_r <= rdata;
                    end
                end
                default: begin
                    aw_done_r <= aw_done_r;
                end
            endcase
        end
    end

`ifdef AXI4LITE_RESP_CHECK_EN
    logic err_r;

    // Capture error status from whichever response channel completes
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RDATA: begin
                    if (rvalid) begin
                        err_r <= is_error_resp(rresp);
                    end
                end
                ST_WRESP: begin
                    if (bvalid) begin
                        err_r <= is_error_resp(bresp);
                    end
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end

    // Error is only meaningful alongside the completion pulse.
    assign rsp_err = rsp_valid_s & err_r;
`else
    // Response codes are deliberately ignored in this build.
    logic unused_resp_s;
    assign unused_resp_s = ^{rresp, bresp, is_error_resp(2'b00)};
    assign rsp_err       = 1'b0;
`endif

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_s;
    assign rsp_rdata = rdata_r;

    assign araddr    = addr_r;
    assign arvalid   = arvalid_s;
    assign rready    = rready_s;

    assign awaddr    = addr_r;
    assign awvalid   = awvalid_s;
    assign wdata     = wdata_r;
    assign wstrb     = wstrb_r;
    assign wvalid    = wvalid_s;
    assign bready    = bready_s;

endmodule

// File: tb/tb_axi4lite_master_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axi4lite_master_controller. The bench plays both the
// cache and a directed AXI4-Lite responder, cycle by cycle. Expected responses
// are queued when a request is driven and compared when rsp_valid pulses.
// Inputs are driven and outputs sampled on the falling edge of aclk.
// -----------------------------------------------------------------------------
module tb_axi4lite_master_controller;

    logic        aclk;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

`ifdef AXI4LITE_RESP_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          rsp_count = 0;
    int          exp_count = 0;
    int          count_before;
    logic [31:0] last_rdata = 32'h0;

    axi4lite_master_controller #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic [1:0] resp);
        return ERR_EN & resp[1];
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        exp_q.push_back(x);
        exp_count++;
    endtask

    // Scoreboard: every rsp_valid pulse must match the oldest queued expectation
    always @(negedge aclk) begin
        if (rsp_valid === 1'b1) begin
            exp_t e;
            rsp_count++;
            chk("rsp_expected", {63'd0, rsp_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end
    end

    // Zero-wait read: accept c0, AR c1, R c2, response c3
    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        @(negedge aclk);
        chk("rd_req_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        push_exp(d, exp_err(r));
        @(negedge aclk);
        chk("rd_arvalid", {63'd0, arvalid}, 64'd1);
        chk("rd_araddr", {32'd0, araddr}, {32'd0, a});
        req_valid = 1'b0; arready = 1'b1;
        @(negedge aclk);
        chk("rd_rready", {63'd0, rready}, 64'd1);
        arready = 1'b0; rvalid = 1'b1; rdata = d; rresp = r;
        @(negedge aclk);
        chk("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        rvalid = 1'b0;
        last_rdata = d;
    endtask

    // Zero-wait write: accept c0, AW+W c1, B c2, response c3
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        @(negedge aclk);
        chk("wr_req_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        push_exp(last_rdata, exp_err(r));
        @(negedge aclk);
        chk("wr_awvalid", {63'd0, awvalid}, 64'd1);
        chk("wr_wvalid", {63'd0, wvalid}, 64'd1);
        chk("wr_awaddr", {32'd0, awaddr}, {32'd0, a});
        chk("wr_wdata", {32'd0, wdata}, {32'd0, d});
        req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge aclk);
        chk("wr_bready", {63'd0, bready}, 64'd1);
        chk("wr_valids_low", {62'd0, awvalid, wvalid}, 64'd0);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = r;
        @(negedge aclk);
        chk("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        bvalid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_ctrl", {57'd0, rsp_valid, rsp_err, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
        chk("rst_araddr", {32'd0, araddr}, 64'd0);
        chk("rst_awaddr", {32'd0, awaddr}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_wstrb", {60'd0, wstrb}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        aresetn = 1'b1;

        // Read, zero-wait responder
        do_read(32'h40, 32'hDEADBEEF, 2'b00);

        // Write with AW at c1, W delayed to c4, B at c6
        @(negedge aclk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h12345678;
        push_exp(last_rdata, 1'b0);
        @(negedge aclk);
        chk("w2_awvalid_c1", {63'd0, awvalid}, 64'd1);
        chk("w2_wvalid_c1", {63'd0, wvalid}, 64'd1);
        chk("w2_awaddr", {32'd0, awaddr}, 64'h80);
        chk("w2_wstrb", {60'd0, wstrb}, 64'hF);
        req_valid = 1'b0; awready = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            @(negedge aclk);
            awready = 1'b0;
            chk("w2_awvalid_low", {63'd0, awvalid}, 64'd0);
            chk("w2_wvalid_held", {63'd0, wvalid}, 64'd1);
            chk("w2_wdata_stable", {32'd0, wdata}, 64'h12345678);
            if (c == 4) wready = 1'b1;
        end
        @(negedge aclk);
        chk("w2_wvalid_c5", {63'd0, wvalid}, 64'd0);
        chk("w2_bready_c5", {63'd0, bready}, 64'd1);
        wready = 1'b0;
        @(negedge aclk);
        chk("w2_rsp_c6", {63'd0, rsp_valid}, 64'd0);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge aclk);
        chk("w2_rsp_c7", {63'd0, rsp_valid}, 64'd1);
        bvalid = 1'b0;
        @(negedge aclk);
        chk("w2_rsp_c8", {63'd0, rsp_valid}, 64'd0);
        chk("w2_idle_c8", {63'd0, req_ready}, 64'd1);

        // Read with arready low 5 cycles and rvalid 3 cycles after AR
        count_before = rsp_count;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
        push_exp(32'hCAFEF00D, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge aclk);
            req_valid = 1'b0;
            chk("r3_arvalid_held", {63'd0, arvalid}, 64'd1);
            chk("r3_araddr_stable", {32'd0, araddr}, 64'h100);
            chk("r3_req_ready_low", {63'd0, req_ready}, 64'd0);
            if (c == 6) arready = 1'b1;
        end
        for (int c = 7; c <= 9; c++) begin
            @(negedge aclk);
            arready = 1'b0;
            chk("r3_rready", {63'd0, rready}, 64'd1);
            chk("r3_no_rsp", {63'd0, rsp_valid}, 64'd0);
            if (c == 9) begin rvalid = 1'b1; rdata = 32'hCAFEF00D; end
        end
        @(negedge aclk);
        chk("r3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        rvalid = 1'b0;
        last_rdata = 32'hCAFEF00D;
        @(negedge aclk);
        chk("r3_req_ready_back", {63'd0, req_ready}, 64'd1);
        @(negedge aclk);
        chk("r3_one_pulse", rsp_count, count_before + 1);

        // Write then read back-to-back with req_valid held high
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h55AA55AA;
        awready = 1'b1; wready = 1'b1;
        push_exp(32'hCAFEF00D, 1'b0);
        @(negedge aclk);
        chk("b2b_aw_w", {62'd0, awvalid, wvalid}, 64'd3);
        req_we = 1'b0; req_addr = 32'h300;
        push_exp(32'h0BADF00D, 1'b0);
        @(negedge aclk);
        chk("b2b_bready", {63'd0, bready}, 64'd1);
        chk("b2b_no_early_ar_c2", {63'd0, arvalid}, 64'd0);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        @(negedge aclk);
        chk("b2b_wr_rsp", {63'd0, rsp_valid}, 64'd1);
        chk("b2b_not_ready_in_resp", {63'd0, req_ready}, 64'd0);
        bvalid = 1'b0;
        @(negedge aclk);
        chk("b2b_idle_ready", {63'd0, req_ready}, 64'd1);
        chk("b2b_no_early_ar_c4", {63'd0, arvalid}, 64'd0);
        chk("b2b_rdata_kept", {32'd0, rsp_rdata}, 64'hCAFEF00D);
        @(negedge aclk);
        chk("b2b_arvalid", {63'd0, arvalid}, 64'd1);
        chk("b2b_araddr", {32'd0, araddr}, 64'h300);
        req_valid = 1'b0; arready = 1'b1;
        @(negedge aclk);
        chk("b2b_rready", {63'd0, rready}, 64'd1);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BADF00D;
        @(negedge aclk);
        chk("b2b_rd_rsp", {63'd0, rsp_valid}, 64'd1);
        rvalid = 1'b0;
        last_rdata = 32'h0BADF00D;

        // Reset asserted while waiting in WRESP
        @(negedge aclk);
        count_before = rsp_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h400; req_wdata = 32'hA5A5A5A5;
        awready = 1'b1; wready = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        chk("rw_aw_w", {62'd0, awvalid, wvalid}, 64'd3);
        @(negedge aclk);
        chk("rw_in_wresp", {63'd0, bready}, 64'd1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        chk("rw_async_ctrl", {58'd0, bready, awvalid, wvalid, arvalid, rready, rsp_valid}, 64'd0);
        chk("rw_async_idle", {63'd0, req_ready}, 64'd1);
        chk("rw_async_wdata", {32'd0, wdata}, 64'd0);
        chk("rw_async_rdata", {32'd0, rsp_rdata}, 64'd0);
        repeat (2) @(negedge aclk);
        bvalid = 1'b0; aresetn = 1'b1;
        last_rdata = 32'h0;
        @(negedge aclk);
        chk("rw_no_rsp", rsp_count, count_before);
        do_read(32'h44, 32'h600DCAFE, 2'b00);

        // Response code handling
        do_write(32'h88, 32'hFEEDFACE, 2'b10);
        do_read(32'h8C, 32'h11223344, 2'b11);
        do_read(32'h90, 32'h99887766, 2'b01);
        do_write(32'h94, 32'h00000001, 2'b00);

        repeat (3) @(negedge aclk);
        chk("queue_drained", exp_q.size(), 64'd0);
        chk("rsp_total", rsp_count, exp_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
